alu32_seq: RTL

Sequenced 32-bit ALU stage that accepts operand/opcode transactions over a valid/ready handshake. It computes the bitwise (AND/OR/XOR) and arithmetic (ADD/SUB) results in one cycle, and performs shifts iteratively at one bit per cycle. The registered result and flags are held for the downstream writeback stage under a second valid/ready handshake. It sits between operand fetch and writeback and is the sequential wrapper around the combinational 32-bit logic units.

---
 rtl/alu32_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu32_seq.sv
// Sequenced 32-bit ALU: bitwise/add/sub finish in one cycle, shifts iterate one bit
// per cycle; the registered result and flags are held under a valid/ready output.
module alu32_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               carry,
   output logic               ovf,
   output logic [1:0]         dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; valid never waits on ready, and payload is sampled only on that edge.

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 carry_q, carry_d;
   logic                 ovf_q, ovf_d;
   logic [WIDTH-1:0]     work_q, work_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]           sop_q, sop_d;

   logic [WIDTH-1:0]     b_eff;
   logic [WIDTH:0]       sum;
   logic                 add_ovf;
   logic [WIDTH-1:0]     work_shifted;
   logic [SHAMT_W-1:0]   shamt;

   // SUB is a + ~b + 1, so bit WIDTH of the sum is the no-borrow flag.
   always_comb begin
      b_eff   = (op == OP_SUB) ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
      add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      shamt   = b[SHAMT_W-1:0];
   end

   // sop_q holds op[1:0] of the shift: 01 SLL, 10 SRL, 11 SRA.
   always_comb begin
      case (sop_q)
         2'b01:   work_shifted = {work_q[WIDTH-2:0], 1'b0};
         2'b10:   work_shifted = {1'b0, work_q[WIDTH-1:1]};
         default: work_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      sop_d    = sop_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = DONE;
               case (op)
                  OP_AND: result_d = a & b;
                  OP_OR:  result_d = a | b;
                  OP_XOR: result_d = a ^ b;
                  OP_ADD, OP_SUB: begin
                     result_d = sum[WIDTH-1:0];
                     carry_d  = sum[WIDTH];
                     ovf_d    = add_ovf;
                  end
                  default: begin
                     result_d = a;
                     if (shamt != '0) begin
                        result_d = result_q;
                        work_d   = a;
                        cnt_d    = shamt;
                        sop_d    = op[1:0];
                        carry_d  = carry_q;
                        ovf_d    = ovf_q;
                        state_d  = SHIFT;
                     end
                  end
               endcase
               zero_d = (state_d == DONE) ? (result_d == '0) : zero_q;
            end
         end
         SHIFT: begin
            work_d = work_shifted;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = work_shifted;
               zero_d   = (work_shifted == '0);
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         work_q   <= '0;
         cnt_q    <= '0;
         sop_q    <= 2'b00;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         sop_q    <= sop_d;
      end
   end

   assign in_ready    = (state_q == IDLE) && rst_n;
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign zero        = zero_q;
   assign carry       = carry_q;
   assign ovf         = ovf_q;
   assign dbg_state_o = state_q;

endmodule
